bcd_lcd_writer: RTL and testbench
=================================

# bcd_lcd_writer

Downstream consumer of the 3-digit BCD counter value. On a start strobe it converts a 12-bit packed BCD value into ASCII characters with optional leading-zero blanking. It then streams a DDRAM address command plus four character bytes to the ST7920 12864 LCD byte driver over a valid/ready handshake. One value is written per start; the block is idle otherwise.

## Interface
Parameters:
- DDRAM_ADDR, 8'h80, command byte sent first (ST7920 "set DDRAM address", row 0 col 0).
- BLANK_LEADING, 1, 1 = replace leading zeros with space; 0 = always print three digits.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- bcd_in  in  12  packed BCD, [11:8] hundreds, [7:4] tens, [3:0] ones; sampled only on accepted start.
- start  in  1  request to write bcd_in; accepted only when busy=0.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  single-cycle pulse after the last byte handshake.
- out_data  out  8  byte to LCD driver.
- out_rs  out  1  0 = command byte, 1 = character data byte.
- out_valid  out  1  out_data/out_rs are valid.
- out_ready  in  1  LCD driver accepts byte when out_valid && out_ready at rising edge.

## Operation
- States: IDLE, ADDR, HUND, TENS, ONES, PAD, FIN.
- IDLE: start=1 latches bcd_in into an internal register; next state ADDR. start while busy is ignored; no queueing.
- ADDR: out_data=DDRAM_ADDR, out_rs=0.
- HUND/TENS/ONES: out_rs=1, out_data=ASCII of the latched digit.
- PAD: out_data=8'h20 (space), out_rs=1. Pads to an even count, because each ST7920 DDRAM address holds two half-width characters.
- Each of ADDR..PAD advances only on handshake (out_valid && out_ready). PAD handshake → FIN. FIN → IDLE unconditionally.
- Digit encoding: 0-9 → 8'h30+digit. Any nibble 10-15 → 8'h3F ('?'). An invalid nibble counts as non-zero for blanking.
- Blanking (BLANK_LEADING=1):
  - hundreds==0 → space;
  - hundreds==0 && tens==0 → tens also space;
  - ones never blanked.
  - With BLANK_LEADING=0, no blanking.
- Byte interface rules:
  - Once out_valid rises, out_data/out_rs hold stable until the handshake.
  - out_valid never drops without a handshake, except on reset.
- Reset (async assert, any state): state=IDLE, out_valid=0, out_data=8'h00, out_rs=0, busy=0, done=0, latched value=12'h000. A transfer in progress is abandoned. No partial byte is replayed after reset.

## Timing
- All outputs registered.
- Start accepted at edge N: busy=1 and out_valid=1 with the ADDR byte from cycle N+1.
- Handshakes are back-to-back: the byte after a handshake at edge K is valid in cycle K+1, with no bubble.
- With out_ready tied high: bytes in cycles N+1..N+5, FIN in N+6 with done=1 and busy=0. A new start may be accepted in N+6.
- out_ready low stretches the current state indefinitely; latency is 6 cycles plus total stall cycles.
- done is high for exactly one cycle per completed transfer. It never asserts for an aborted (reset) transfer.
- bcd_in changes after acceptance do not affect the bytes sent.

## Test plan
- After reset, ready=1, bcd_in=12'h259, start pulse → bytes (rs,data) = (0,80),(1,32),(1,35),(1,39),(1,20) in 5 consecutive cycles. done pulses one cycle later.
- BLANK_LEADING=1, bcd_in=12'h007 → (0,80),(1,20),(1,20),(1,37),(1,20). Repeat with 12'h040 → (1,20),(1,34),(1,30). Repeat with 12'h000 → (1,20),(1,20),(1,30). With BLANK_LEADING=0, 12'h007 → (1,30),(1,30),(1,37).
- bcd_in=12'hA05 → hundreds byte 3F, tens byte 30 (not blanked), ones byte 35.
- bcd_in=12'h123, out_ready pseudo-random ~50% → same 5 bytes in order. Data/rs stable during every stall; exactly one done.
- start re-pulsed while busy, bcd_in changed to 12'h999 mid-transfer → original bytes only, one done. A start in the done cycle with 12'h999 → second sequence 39,39,39.
- rst_n asserted during the TENS state → outputs immediately return to reset values and no done pulse. A following start with 12'h100 → full correct sequence 31,30,30.

Source files
------------

// File: rtl/bcd_lcd_writer.sv
// Streams one packed-BCD value to the ST7920 byte driver: a DDRAM address
// command, three ASCII digits (optionally leading-zero blanked) and a pad space.
module bcd_lcd_writer #(
    parameter logic [7:0] DDRAM_ADDR    = 8'h80,
    parameter logic       BLANK_LEADING = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] bcd_in,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [7:0]  out_data,
    output logic        out_rs,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [2:0]  dbg_state
);

    // Byte handshake: a byte transfers on a rising edge where out_valid && out_ready.
    // Once raised, out_valid, out_data and out_rs hold until that handshake.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        HUND = 3'd2,
        TENS = 3'd3,
        ONES = 3'd4,
        PAD  = 3'd5,
        FIN  = 3'd6
    } state_t;

    state_t      state, state_d;
    logic [11:0] bcd_q;
    logic        load;
    logic        hs;
    logic        lead_h, lead_t;
    logic [7:0]  hund_ch, tens_ch, ones_ch;
    logic [7:0]  data_d;
    logic        rs_d, valid_d, done_d;

    function automatic logic [7:0] to_ascii(input logic [3:0] d);
        return (d > 4'd9) ? 8'h3F : (8'h30 + {4'h0, d});
    endfunction

    assign dbg_state = state;
    assign hs        = out_valid && out_ready;

    // Invalid nibbles are non-zero, so they stop blanking like any real digit.
    assign lead_h  = BLANK_LEADING && (bcd_q[11:8] == 4'd0);
    assign lead_t  = lead_h && (bcd_q[7:4] == 4'd0);
    assign hund_ch = lead_h ? 8'h20 : to_ascii(bcd_q[11:8]);
    assign tens_ch = lead_t ? 8'h20 : to_ascii(bcd_q[7:4]);
    assign ones_ch = to_ascii(bcd_q[3:0]);

    always_comb begin
        state_d = state;
        load    = 1'b0;
        case (state)
            // FIN is the done cycle; busy is already low, so a start there is taken.
            IDLE, FIN: begin
                if (start) begin
                    state_d = ADDR;
                    load    = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            ADDR:    if (hs) state_d = HUND;
            HUND:    if (hs) state_d = TENS;
            TENS:    if (hs) state_d = ONES;
            ONES:    if (hs) state_d = PAD;
            PAD:     if (hs) state_d = FIN;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are registered with it.
    always_comb begin
        data_d  = 8'h00;
        rs_d    = 1'b0;
        valid_d = 1'b0;
        done_d  = 1'b0;
        case (state_d)
            ADDR: begin data_d = DDRAM_ADDR; valid_d = 1'b1; end
            HUND: begin data_d = hund_ch; rs_d = 1'b1; valid_d = 1'b1; end
            TENS: begin data_d = tens_ch; rs_d = 1'b1; valid_d = 1'b1; end
            ONES: begin data_d = ones_ch; rs_d = 1'b1; valid_d = 1'b1; end
            PAD:  begin data_d = 8'h20;   rs_d = 1'b1; valid_d = 1'b1; end
            FIN:  done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bcd_q     <= 12'h000;
            out_data  <= 8'h00;
            out_rs    <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            out_data  <= data_d;
            out_rs    <= rs_d;
            out_valid <= valid_d;
            busy      <= valid_d;
            done      <= done_d;
            if (load) bcd_q <= bcd_in;
        end
    end

endmodule

// File: tb/tb_bcd_lcd_writer.sv
// Bench for bcd_lcd_writer: two instances (blanking on/off) checked every cycle
// against a byte-list model, plus literal byte sequences for the directed cases.
module tb_bcd_lcd_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] bcd_in = 12'h000;
    logic        start = 1'b0;
    logic        out_ready = 1'b1;

    logic        busy_a, done_a, out_rs_a, out_valid_a;
    logic [7:0]  out_data_a;
    logic [2:0]  dbg_a;
    logic        busy_b, done_b, out_rs_b, out_valid_b;
    logic [7:0]  out_data_b;
    logic [2:0]  dbg_b;

    int errors = 0;
    int checks = 0;
    bit rdy_rand = 1'b0;

    // Model: -1 idle, 0..4 index of the byte on offer, 5 done cycle.
    int          m_idx = -1;
    logic [44:0] m_bytes_a = '0;
    logic [44:0] m_bytes_b = '0;

    logic [8:0] log_a[$];
    logic [8:0] log_b[$];
    logic [8:0] exp_q[$];

    bcd_lcd_writer #(.DDRAM_ADDR(8'h80), .BLANK_LEADING(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .start(start),
        .busy(busy_a), .done(done_a), .out_data(out_data_a), .out_rs(out_rs_a),
        .out_valid(out_valid_a), .out_ready(out_ready), .dbg_state(dbg_a)
    );

    bcd_lcd_writer #(.DDRAM_ADDR(8'h80), .BLANK_LEADING(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .start(start),
        .busy(busy_b), .done(done_b), .out_data(out_data_b), .out_rs(out_rs_b),
        .out_valid(out_valid_b), .out_ready(out_ready), .dbg_state(dbg_b)
    );

    // ---------------- clock ----------------
    initial forever #5 clk = ~clk;

    // ---------------- model ----------------
    function automatic logic [7:0] asc(input logic [3:0] d);
        return (d > 4'd9) ? 8'h3F : (8'h30 + {4'h0, d});
    endfunction

    function automatic logic [44:0] make_bytes(input logic [11:0] v, input bit blank);
        logic [7:0] ch, ct, co;
        ch = asc(v[11:8]);
        ct = asc(v[7:4]);
        co = asc(v[3:0]);
        if (blank && v[11:8] == 4'd0) ch = 8'h20;
        if (blank && v[11:8] == 4'd0 && v[7:4] == 4'd0) ct = 8'h20;
        return {1'b0, 8'h80, 1'b1, ch, 1'b1, ct, 1'b1, co, 1'b1, 8'h20};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_idx = -1;
        end else if (m_idx == -1 || m_idx == 5) begin
            if (start) begin
                m_bytes_a = make_bytes(bcd_in, 1'b1);
                m_bytes_b = make_bytes(bcd_in, 1'b0);
                m_idx = 0;
            end else begin
                m_idx = -1;
            end
        end else if (out_ready) begin
            m_idx = m_idx + 1;
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : compare
        logic ev;
        ev = (m_idx >= 0 && m_idx <= 4);
        chk("busy_a",  busy_a,      ev);
        chk("valid_a", out_valid_a, ev);
        chk("done_a",  done_a,      m_idx == 5);
        chk("busy_b",  busy_b,      ev);
        chk("valid_b", out_valid_b, ev);
        chk("done_b",  done_b,      m_idx == 5);
        if (ev) begin
            chk("byte_a", {out_rs_a, out_data_a}, m_bytes_a[44 - 9*m_idx -: 9]);
            chk("byte_b", {out_rs_b, out_data_b}, m_bytes_b[44 - 9*m_idx -: 9]);
        end
        if (out_valid_a && out_ready) log_a.push_back({out_rs_a, out_data_a});
        if (out_valid_b && out_ready) log_b.push_back({out_rs_b, out_data_b});
    end

    task automatic check_log(input string name, input bit use_b, input logic [44:0] lit);
        logic [8:0] got;
        for (int i = 0; i < 5; i++) exp_q.push_back(lit[44 - 9*i -: 9]);
        chk({name, "_count"}, use_b ? log_b.size() : log_a.size(), 16'd5);
        for (int i = 0; i < 5; i++) begin
            if (use_b) got = (log_b.size() > i) ? log_b[i] : 9'h1FF;
            else       got = (log_a.size() > i) ? log_a[i] : 9'h1FF;
            chk(name, got, exp_q.pop_front());
        end
    endtask

    // ---------------- drivers ----------------
    initial forever begin
        @(posedge clk);
        #1;
        out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic wait_fin();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (m_idx == 5) seen = 1'b1;
        end
        chk("fin_timeout", seen, 1'b1);
    endtask

    // Called at #1 after an edge with the writer idle or in its done cycle.
    task automatic xfer(input logic [11:0] v);
        log_a.delete();
        log_b.delete();
        bcd_in = v;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_fin();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_data", out_data_a, 8'h00);
        chk("rst_rs",   out_rs_a,   1'b0);
        chk("rst_busy", busy_a,     1'b0);
        @(posedge clk);
        #1;

        xfer(12'h259);
        check_log("seq_259", 1'b0, {9'h080, 9'h132, 9'h135, 9'h139, 9'h120});
        xfer(12'h007);
        check_log("seq_007", 1'b0, {9'h080, 9'h120, 9'h120, 9'h137, 9'h120});
        check_log("seq_007_nb", 1'b1, {9'h080, 9'h130, 9'h130, 9'h137, 9'h120});
        xfer(12'h040);
        check_log("seq_040", 1'b0, {9'h080, 9'h120, 9'h134, 9'h130, 9'h120});
        xfer(12'h000);
        check_log("seq_000", 1'b0, {9'h080, 9'h120, 9'h120, 9'h130, 9'h120});
        xfer(12'hA05);
        check_log("seq_a05", 1'b0, {9'h080, 9'h13F, 9'h130, 9'h135, 9'h120});

        rdy_rand = 1'b1;
        xfer(12'h123);
        check_log("seq_123_stall", 1'b0, {9'h080, 9'h131, 9'h132, 9'h133, 9'h120});
        rdy_rand = 1'b0;
        @(posedge clk);
        #1;

        // start re-pulsed while busy with a changed value
        log_a.delete();
        log_b.delete();
        bcd_in = 12'h456;
        start  = 1'b1;
        @(posedge clk);
        #1;
        bcd_in = 12'h999;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_fin();
        check_log("seq_busy_start", 1'b0, {9'h080, 9'h134, 9'h135, 9'h136, 9'h120});
        xfer(12'h999);
        check_log("seq_done_start", 1'b0, {9'h080, 9'h139, 9'h139, 9'h139, 9'h120});
        @(posedge clk);
        #1;

        // reset asserted while the tens byte is on offer
        bcd_in = 12'h345;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 20 && m_idx != 2; i++) begin
            @(posedge clk);
            #1;
        end
        chk("reach_tens", m_idx == 2, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid_a, 1'b0);
        chk("mid_rst_data",  out_data_a,  8'h00);
        chk("mid_rst_busy",  busy_a,      1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        xfer(12'h100);
        check_log("seq_100", 1'b0, {9'h080, 9'h131, 9'h130, 9'h130, 9'h120});
        check_log("seq_100_nb", 1'b1, {9'h080, 9'h131, 9'h130, 9'h130, 9'h120});

        // random traffic, stalls, overlapping starts and occasional resets
        rdy_rand = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk);
            #1;
            start  = ($urandom_range(0, 3) == 0);
            bcd_in = {4'($urandom_range(0, 11)), 4'($urandom_range(0, 11)),
                      4'($urandom_range(0, 11))};
            rst_n  = ($urandom_range(0, 199) != 0);
        end
        @(posedge clk);
        #1;
        start    = 1'b0;
        rst_n    = 1'b1;
        rdy_rand = 1'b0;
        repeat (20) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
